// File: rtl/pri_rv32_lsu_pkg.sv
// Shared constants and types for the priRV32 load/store unit:
// funct3 encodings, exception cause codes and LSU FSM states.
package pri_rv32_pkg;

    // funct3 encodings (stores reuse 000/001/010 for SB/SH/SW)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Exception cause codes
    localparam logic [1:0] CAUSE_LD_MISALIGN = 2'b00;
    localparam logic [1:0] CAUSE_ST_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_LD_FAULT    = 2'b10;
    localparam logic [1:0] CAUSE_ST_FAULT    = 2'b11;

    // LSU FSM states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic op_supported(input logic we, input logic [2:0] op);
        logic ok;
        ok = (op == F3_B) || (op == F3_H) || (op == F3_W);
        if (!we) begin
            ok = ok || (op == F3_BU) || (op == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0. Only meaningful for
    // supported ops; unsupported ops are screened out first.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op[1:0] == 2'b01) && off[0]) || ((op[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/pri_rv32_lsu_if.sv
// Data-bus interface between the LSU (master) and memory (slave):
// request/grant handshake followed by a single response beat.
interface pri_rv32_lsu_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/pri_rv32_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for
// the bus, and byte-lane extraction plus sign/zero extension for loads.
module pri_rv32_lsu_align
    import pri_rv32_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);
    logic [31:0] w_shifted;

    // Bring the addressed byte/halfword down to bit 0.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    // Store lanes: replicate the datum so every lane carries it; loads use all lanes.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_we) begin
            case (i_op[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_off;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

    // Load extend: signed for LB/LH, unsigned for LBU/LHU, full word for LW.
    always_comb begin
        o_ldata = w_shifted;
        case (i_op)
            F3_B:    o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_ldata = {24'b0, w_shifted[7:0]};
            F3_H:    o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_ldata = {16'b0, w_shifted[15:0]};
            default: o_ldata = w_shifted;
        endcase
    end
endmodule

// File: rtl/pri_rv32_lsu.sv
// priRV32 load/store unit: accepts one EXU memory op at a time, runs a
// single-outstanding req/gnt/rvalid bus transaction with a timeout, and
// ends every op with a one-cycle DONE carrying either a register write or
// an exception.
module pri_rv32_lsu
    import pri_rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exu_valid_i,
    output logic        exu_ready_o,
    input  logic        exu_we_i,
    input  logic [2:0]  exu_op_i,
    input  logic [31:0] exu_addr_i,
    input  logic [31:0] exu_wdata_i,
    input  logic [4:0]  exu_rd_i,
    pri_rv32_lsu_if.master mem,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        busy_o,
    output logic        exc_valid_o,
    output logic [1:0]  exc_cause_o,
    output logic [31:0] exc_addr_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state, w_state_next;
    logic             r_we;
    logic [2:0]       r_op;
    logic [31:0]      r_addr, r_wdata, r_ldata;
    logic [4:0]       r_rd;
    logic             r_exc;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept, w_bad_op, w_misaligned, w_resp, w_timeout, w_in_req;
    logic [3:0]       w_be;
    logic [31:0]      w_st_data, w_ld_data;

    assign w_accept     = (r_state == LSU_IDLE) && exu_valid_i;
    assign w_bad_op     = !op_supported(exu_we_i, exu_op_i);
    assign w_misaligned = op_misaligned(exu_op_i, exu_addr_i[1:0]);
    // rvalid only counts in WAIT; in REQ or IDLE it is ignored.
    assign w_resp       = (r_state == LSU_WAIT) && mem.mem_rvalid_i;
    // A response arriving on the last allowed cycle still wins over the timeout.
    assign w_timeout    = ((r_state == LSU_REQ) || (r_state == LSU_WAIT)) &&
                          (r_cnt == CNT_LAST) && !w_resp;
    assign w_in_req     = (r_state == LSU_REQ);

    pri_rv32_lsu_align u_align (
        .i_we    (r_we),
        .i_op    (r_op),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem.mem_rdata_i),
        .o_be    (w_be),
        .o_wdata (w_st_data),
        .o_ldata (w_ld_data)
    );

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (exu_valid_i) begin
                    w_state_next = (w_bad_op || w_misaligned) ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (w_timeout)          w_state_next = LSU_DONE;
                else if (mem.mem_gnt_i) w_state_next = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (w_resp || w_timeout) w_state_next = LSU_DONE;
            end
            LSU_DONE: w_state_next = LSU_IDLE;
            default:  w_state_next = LSU_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= LSU_IDLE;
        else       r_state <= w_state_next;
    end

    // Timeout counter: cleared at accept, counts every REQ/WAIT cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                          r_cnt <= '0;
        else if (w_accept)                                  r_cnt <= '0;
        else if ((r_state == LSU_REQ) || (r_state == LSU_WAIT)) r_cnt <= r_cnt + 1'b1;
    end

    // Operation latches, exception status and captured load data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
            r_exc   <= 1'b0;
            r_cause <= '0;
            r_ldata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= exu_we_i;
                r_op    <= exu_op_i;
                r_addr  <= exu_addr_i;
                r_wdata <= exu_wdata_i;
                r_rd    <= exu_rd_i;
                r_exc   <= w_bad_op || w_misaligned;
                if (w_bad_op) r_cause <= exu_we_i ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                else          r_cause <= exu_we_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            end else if (w_timeout || (w_resp && mem.mem_err_i)) begin
                r_exc   <= 1'b1;
                r_cause <= r_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end
            if (w_resp && !mem.mem_err_i && !r_we) begin
                r_ldata <= w_ld_data;
            end
        end
    end

    // Outputs are decoded from state and latched registers only.
    assign exu_ready_o     = (r_state == LSU_IDLE);
    assign busy_o          = (r_state != LSU_IDLE);
    assign mem.mem_req_o   = w_in_req;
    assign mem.mem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem.mem_we_o    = w_in_req && r_we;
    assign mem.mem_be_o    = w_in_req ? w_be : 4'b0000;
    assign mem.mem_wdata_o = w_in_req ? w_st_data : 32'h0;
    assign reg_we_o        = (r_state == LSU_DONE) && !r_exc && !r_we && (r_rd != 5'd0);
    assign reg_waddr_o     = r_rd;
    assign reg_wdata_o     = r_ldata;
    assign exc_valid_o     = (r_state == LSU_DONE) && r_exc;
    assign exc_cause_o     = r_cause;
    assign exc_addr_o      = r_addr;
endmodule

// File: tb/tb_pri_rv32_lsu.sv
// Testbench for pri_rv32_lsu: a table of directed vectors, hand-written
// reset/late-response sequences, and randomized ops checked against a
// behavioural model of the access rules.
module tb_pri_rv32_lsu;
    localparam int T      = 16;
    localparam int BUDGET = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exu_valid = 1'b0, exu_we = 1'b0;
    logic [2:0]  exu_op = '0;
    logic [31:0] exu_addr = '0, exu_wdata = '0;
    logic [4:0]  exu_rd = '0;
    logic        exu_ready, reg_we, busy, exc_valid;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, exc_addr;
    logic [1:0]  exc_cause;

    pri_rv32_lsu_if bus();

    always #5 clk = ~clk;

    pri_rv32_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .exu_valid_i(exu_valid), .exu_ready_o(exu_ready), .exu_we_i(exu_we),
        .exu_op_i(exu_op), .exu_addr_i(exu_addr), .exu_wdata_i(exu_wdata), .exu_rd_i(exu_rd),
        .mem(bus),
        .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
        .busy_o(busy), .exc_valid_o(exc_valid), .exc_cause_o(exc_cause), .exc_addr_o(exc_addr)
    );

    typedef struct {
        bit        we;
        bit [2:0]  op;
        bit [31:0] addr, wdata;
        bit [4:0]  rd;
        bit [31:0] rdata;
        bit        err;
        int        gd, rvd;            // gnt delay (REQ cycles before gnt), rvalid delay
        bit [31:0] e_maddr;
        bit [3:0]  e_be;
        bit [31:0] e_mwdata;
        int        e_nreq;
        bit        e_regwe;
        bit [31:0] e_regwdata;
        bit        e_exc;
        bit [1:0]  e_cause;
        int        e_lat;              // cycles from accept to DONE
    } vec_t;

    typedef struct {
        int          lat, nreq, n_regwe, n_exc;
        bit          both, unstable, hung;
        logic [31:0] maddr, mwdata, waddr, regwdata, eaddr;
        logic [3:0]  be;
        logic        mwe;
        logic [1:0]  cause;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit we, bit [2:0] op, bit [31:0] addr, bit [31:0] wdata,
                                bit [4:0] rd, bit [31:0] rdata, bit err, int gd, int rvd,
                                bit [31:0] maddr, bit [3:0] be, bit [31:0] mwdata, int nreq,
                                bit regwe, bit [31:0] regwdata, bit exc, bit [1:0] cause, int lat);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
        v.err = err; v.gd = gd; v.rvd = rvd; v.e_maddr = maddr; v.e_be = be; v.e_mwdata = mwdata;
        v.e_nreq = nreq; v.e_regwe = regwe; v.e_regwdata = regwdata; v.e_exc = exc;
        v.e_cause = cause; v.e_lat = lat;
        return v;
    endfunction

    // Reference model: derives expected results from the access rules directly.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        bit     sup;
        int     nb, off;
        longint sh, val;
        r = v;
        r.e_maddr = 0; r.e_be = 0; r.e_mwdata = 0; r.e_nreq = 0; r.e_regwe = 0;
        r.e_regwdata = 0; r.e_exc = 0; r.e_cause = 0;
        sup = v.we ? (v.op <= 2) : (v.op <= 2 || v.op == 4 || v.op == 5);
        nb  = 1 << (v.op % 4);
        off = v.addr % 4;
        if (!sup) begin
            r.e_exc = 1; r.e_cause = v.we ? 2'd3 : 2'd2; r.e_lat = 1;
            return r;
        end
        if ((v.addr % nb) != 0) begin
            r.e_exc = 1; r.e_cause = v.we ? 2'd1 : 2'd0; r.e_lat = 1;
            return r;
        end
        r.e_maddr  = v.addr - off;
        r.e_be     = v.we ? 4'(((1 << nb) - 1) << off) : 4'hF;
        r.e_mwdata = (nb == 4) ? v.wdata :
                     (nb == 2) ? (v.wdata % 65536) * 32'h00010001 : (v.wdata % 256) * 32'h01010101;
        r.e_nreq   = (v.gd + 1 < T) ? v.gd + 1 : T;
        if (v.gd + 1 + v.rvd > T - 1) begin
            r.e_exc = 1; r.e_cause = v.we ? 2'd3 : 2'd2; r.e_lat = T + 1;
            return r;
        end
        r.e_lat = v.gd + v.rvd + 3;
        if (v.err) begin
            r.e_exc = 1; r.e_cause = v.we ? 2'd3 : 2'd2;
            return r;
        end
        if (!v.we && v.rd != 0) begin
            r.e_regwe = 1;
            sh  = v.rdata >> (8 * off);
            val = sh % (64'd1 << (8 * nb));
            if (v.op < 4 && nb < 4 && val >= (64'd1 << (8 * nb - 1))) val = val - (64'd1 << (8 * nb));
            r.e_regwdata = val[31:0];
        end
        return r;
    endfunction

    // Issue one op, act as the memory, and record what the LSU did.
    task automatic run_op(input vec_t v, output obs_t o);
        bit granted, rvdone, fin;
        int wn;
        o = '{default: 0};
        granted = 0; rvdone = 0; fin = 0; wn = 0;
        chk("ready_before_op", exu_ready, 1'b1);
        exu_valid = 1; exu_we = v.we; exu_op = v.op; exu_addr = v.addr;
        exu_wdata = v.wdata; exu_rd = v.rd;
        @(negedge clk);
        exu_valid = 0; exu_addr = $urandom; exu_wdata = $urandom; exu_rd = 5'($urandom);
        for (int it = 1; it <= BUDGET && !fin; it++) begin
            if (reg_we) begin o.n_regwe++; o.waddr = 32'(reg_waddr); o.regwdata = reg_wdata; end
            if (exc_valid) begin o.n_exc++; o.cause = exc_cause; o.eaddr = exc_addr; end
            if (reg_we && exc_valid) o.both = 1;
            if (!busy) begin o.lat = it - 1; fin = 1; end
            bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_err_i = 0; bus.mem_rdata_i = $urandom;
            if (fin) begin
            end else if (bus.mem_req_o) begin
                o.nreq++;
                if (o.nreq == 1) begin
                    o.maddr = bus.mem_addr_o; o.be = bus.mem_be_o;
                    o.mwe = bus.mem_we_o; o.mwdata = bus.mem_wdata_o;
                end else if (bus.mem_addr_o !== o.maddr || bus.mem_be_o !== o.be ||
                             bus.mem_we_o !== o.mwe || bus.mem_wdata_o !== o.mwdata) begin
                    o.unstable = 1;
                end
                if (!granted && o.nreq - 1 == v.gd) begin bus.mem_gnt_i = 1; granted = 1; end
            end else if (granted && !rvdone) begin
                if (wn == v.rvd) begin
                    bus.mem_rvalid_i = 1; bus.mem_rdata_i = v.rdata; bus.mem_err_i = v.err; rvdone = 1;
                end
                wn++;
            end
            @(negedge clk);
        end
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_err_i = 0;
        if (!fin) o.hung = 1;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input obs_t o);
        $display("[TB] %s we=%0d op=%0d addr=%08h gd=%0d rvd=%0d -> lat=%0d req=%0d regwe=%0d exc=%0d",
                 tag, v.we, v.op, v.addr, v.gd, v.rvd, o.lat, o.nreq, o.n_regwe, o.n_exc);
        chk({tag, ".hung"}, 32'(o.hung), 0);
        chk({tag, ".latency"}, o.lat, v.e_lat);
        chk({tag, ".req_cycles"}, o.nreq, v.e_nreq);
        chk({tag, ".reg_we_pulses"}, o.n_regwe, 32'(v.e_regwe));
        chk({tag, ".exc_pulses"}, o.n_exc, 32'(v.e_exc));
        chk({tag, ".we_and_exc"}, 32'(o.both), 0);
        chk({tag, ".req_unstable"}, 32'(o.unstable), 0);
        if (v.e_nreq > 0) begin
            chk({tag, ".mem_addr"}, o.maddr, v.e_maddr);
            chk({tag, ".mem_be"}, 32'(o.be), 32'(v.e_be));
            chk({tag, ".mem_we"}, 32'(o.mwe), 32'(v.we));
            if (v.we) chk({tag, ".mem_wdata"}, o.mwdata, v.e_mwdata);
        end
        if (v.e_regwe) begin
            chk({tag, ".reg_waddr"}, o.waddr, 32'(v.rd));
            chk({tag, ".reg_wdata"}, o.regwdata, v.e_regwdata);
        end
        if (v.e_exc) begin
            chk({tag, ".exc_cause"}, 32'(o.cause), 32'(v.e_cause));
            chk({tag, ".exc_addr"}, o.eaddr, v.addr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        vec_t v;
        bit   quiet;
        logic [31:0] a;

        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_err_i = 0; bus.mem_rdata_i = 0;

        // Directed vectors: we op addr wdata rd rdata err gd rvd | maddr be mwdata nreq regwe regwdata exc cause lat
        tbl[0]  = mk(1, 3'd0, 32'h103, 32'hA5, 0, 0, 0, 0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 3);
        tbl[1]  = mk(0, 3'd0, 32'h202, 0, 5, 32'h0080FF00, 0, 0, 0, 32'h200, 4'hF, 0, 1, 1, 32'hFFFFFF80, 0, 0, 3);
        tbl[2]  = mk(0, 3'd4, 32'h202, 0, 5, 32'h0080FF00, 0, 0, 0, 32'h200, 4'hF, 0, 1, 1, 32'h00000080, 0, 0, 3);
        tbl[3]  = mk(0, 3'd1, 32'h301, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1);
        tbl[4]  = mk(0, 3'd2, 32'h400, 0, 0, 32'h12345678, 0, 0, 0, 32'h400, 4'hF, 0, 1, 0, 0, 0, 0, 3);
        tbl[5]  = mk(1, 3'd2, 32'h500, 32'hDEADBEEF, 0, 0, 0, 100, 0, 32'h500, 4'hF, 32'hDEADBEEF, 16, 0, 0, 1, 2'd3, 17);
        tbl[6]  = mk(0, 3'd5, 32'h202, 0, 9, 32'h80010000, 0, 1, 2, 32'h200, 4'hF, 0, 2, 1, 32'h00008001, 0, 0, 6);
        tbl[7]  = mk(0, 3'd1, 32'h002, 0, 31, 32'h80010000, 0, 0, 0, 32'h000, 4'hF, 0, 1, 1, 32'hFFFF8001, 0, 0, 3);
        tbl[8]  = mk(1, 3'd1, 32'h006, 32'h1234ABCD, 0, 0, 0, 2, 1, 32'h004, 4'b1100, 32'hABCDABCD, 3, 0, 0, 0, 0, 6);
        tbl[9]  = mk(1, 3'd2, 32'h702, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 1);
        tbl[10] = mk(0, 3'd3, 32'h800, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 1);
        tbl[11] = mk(1, 3'd4, 32'h804, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 1);
        tbl[12] = mk(0, 3'd2, 32'h900, 0, 3, 32'hCAFEF00D, 1, 0, 1, 32'h900, 4'hF, 0, 1, 0, 0, 1, 2'd2, 4);
        tbl[13] = mk(1, 3'd0, 32'h905, 32'h77, 0, 0, 1, 1, 0, 32'h904, 4'b0010, 32'h77777777, 2, 0, 0, 1, 2'd3, 4);
        tbl[14] = mk(0, 3'd2, 32'hA00, 0, 4, 0, 0, 0, 40, 32'hA00, 4'hF, 0, 1, 0, 0, 1, 2'd2, 17);
        tbl[15] = mk(0, 3'd0, 32'h1003, 0, 1, 32'h7F000000, 0, 0, 0, 32'h1000, 4'hF, 0, 1, 1, 32'h0000007F, 0, 0, 3);

        // Reset values while reset is held.
        #1;
        chk("rst.exu_ready", exu_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.mem_req", bus.mem_req_o, 0);
        chk("rst.mem_addr", bus.mem_addr_o, 0);
        chk("rst.mem_be", 32'(bus.mem_be_o), 0);
        chk("rst.mem_we", bus.mem_we_o, 0);
        chk("rst.mem_wdata", bus.mem_wdata_o, 0);
        chk("rst.reg_we", reg_we, 0);
        chk("rst.reg_wdata", reg_wdata, 0);
        chk("rst.exc_valid", exc_valid, 0);
        chk("rst.exc_addr", exc_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i], o);
            check_vec($sformatf("vec%0d", i), tbl[i], o);
        end

        // Late response after a store timeout must be ignored.
        run_op(tbl[5], o);
        check_vec("late_setup", tbl[5], o);
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h11223344;
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_rvalid_i = 0;
            if (reg_we || exc_valid || busy || bus.mem_req_o) quiet = 0;
        end
        $display("[TB] late rvalid while idle");
        chk("late_rvalid_quiet", 32'(quiet), 1);

        // Reset while in REQ.
        exu_valid = 1; exu_we = 1; exu_op = 3'd2; exu_addr = 32'h600; exu_wdata = 32'h1;
        @(negedge clk);
        exu_valid = 0;
        chk("rst_req.req_before", bus.mem_req_o, 1);
        #2 rst = 1;
        #1;
        $display("[TB] reset asserted in REQ");
        chk("rst_req.mem_req", bus.mem_req_o, 0);
        chk("rst_req.busy", busy, 0);
        chk("rst_req.ready", exu_ready, 1);
        @(negedge clk);
        rst = 0;

        // Reset while in WAIT, with a response arriving afterwards.
        exu_valid = 1; exu_we = 0; exu_op = 3'd2; exu_addr = 32'h640; exu_rd = 5'd6;
        @(negedge clk);
        exu_valid = 0;
        bus.mem_gnt_i = 1;
        @(negedge clk);
        bus.mem_gnt_i = 0;
        chk("rst_wait.busy_before", busy, 1);
        #2 rst = 1;
        #1;
        $display("[TB] reset asserted in WAIT");
        chk("rst_wait.busy", busy, 0);
        chk("rst_wait.mem_req", bus.mem_req_o, 0);
        chk("rst_wait.ready", exu_ready, 1);
        @(negedge clk);
        rst = 0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hBADBAD00;
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_rvalid_i = 0;
            if (reg_we || exc_valid || busy) quiet = 0;
        end
        chk("rst_wait.no_writeback", 32'(quiet), 1);
        v = mk(0, 3'd2, 32'h640, 0, 6, 32'h0BADF00D, 0, 0, 0, 32'h640, 4'hF, 0, 1, 1, 32'h0BADF00D, 0, 0, 3);
        run_op(v, o);
        check_vec("after_rst_lw", v, o);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            v.we  = $urandom_range(0, 1);
            v.op  = 3'($urandom);
            a     = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            v.addr  = a;
            v.wdata = $urandom;
            v.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.rdata = $urandom;
            v.err   = ($urandom_range(0, 7) == 0);
            v.gd    = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 17) : $urandom_range(0, 3);
            v.rvd   = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 14) : $urandom_range(0, 3);
            v = model(v);
            run_op(v, o);
            check_vec($sformatf("rnd%0d", i), v, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
